// File: rtl/hwpe_stream_tcdm_reader.sv
`default_nettype none
// ============================================================================
//  Module   : hwpe_stream_tcdm_reader
//  Brief    : Single-port TCDM read engine. Issues a strided sequence of
//             32-bit loads and forwards the returned words, in issue order,
//             as an HWPE stream. A credit-limited response FIFO absorbs
//             stream backpressure so no returned word is ever dropped.
//  Revision : 1.0 - initial release
// ============================================================================
module hwpe_stream_tcdm_reader #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TRANS_W    = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               req_start_i,
   input  logic [31:0]        base_addr_i,
   input  logic [TRANS_W-1:0] trans_size_i,
   input  logic [TRANS_W-1:0] stride_i,
   output logic               ready_start_o,
   output logic               done_o,
   output logic               tcdm_req_o,
   input  logic               tcdm_gnt_i,
   output logic [31:0]        tcdm_add_o,
   output logic               tcdm_wen_o,
   output logic [3:0]         tcdm_be_o,
   output logic [31:0]        tcdm_data_o,
   input  logic [31:0]        tcdm_r_data_i,
   input  logic               tcdm_r_valid_i,
   output logic               stream_valid_o,
   input  logic               stream_ready_i,
   output logic [31:0]        stream_data_o,
   output logic [3:0]         stream_strb_o
);

   localparam int unsigned      PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned      CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      WORKING = 1'b1
   } state_e;

   state_e             state_q;
   logic [31:0]        addr_q;
   logic [TRANS_W-1:0] size_q;
   logic [TRANS_W-1:0] stride_q;
   logic [TRANS_W-1:0] issued_q;
   logic [TRANS_W-1:0] popped_q;
   logic [CNT_W-1:0]   inflight_q;
   logic               drop_q;
   logic               done_q;

   logic [31:0]        fifo_mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;

   logic w_credit_ok;
   logic w_req;
   logic w_gnt;
   logic w_push;
   logic w_valid;
   logic w_pop;
   logic w_last;

   // A request may only be raised while a FIFO slot is reserved for its reply.
   // Credits can only grow while a request waits, so req never drops before gnt.
   assign w_credit_ok = (inflight_q + count_q) < C_DEPTH;
   assign w_req       = (state_q == WORKING) && (issued_q < size_q) && w_credit_ok;
   assign w_gnt       = w_req && tcdm_gnt_i;
   // drop_q marks the single reply still owed to a request granted in a clear cycle.
   assign w_push      = tcdm_r_valid_i && !drop_q;
   assign w_valid     = (count_q != '0);
   assign w_pop       = w_valid && stream_ready_i;
   assign w_last      = w_pop && ((popped_q + TRANS_W'(1)) == size_q);

   assign ready_start_o  = (state_q == IDLE);
   assign done_o         = done_q;
   assign tcdm_req_o     = w_req;
   assign tcdm_add_o     = addr_q;
   assign tcdm_wen_o     = 1'b1;
   assign tcdm_be_o      = 4'hF;
   assign tcdm_data_o    = 32'h0;
   assign stream_valid_o = w_valid;
   assign stream_data_o  = fifo_mem_q[rd_ptr_q];
   assign stream_strb_o  = 4'hF;

   // Transfer control: FSM, address generation, issue/pop/in-flight counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         stride_q   <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         inflight_q <= '0;
         drop_q     <= 1'b0;
         done_q     <= 1'b0;
      end else if (clear_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         size_q     <= '0;
         stride_q   <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         inflight_q <= '0;
         drop_q     <= w_gnt;
         done_q     <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_start_i) begin
                  if (trans_size_i == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state_q  <= WORKING;
                     addr_q   <= base_addr_i;
                     size_q   <= trans_size_i;
                     stride_q <= stride_i;
                     issued_q <= '0;
                     popped_q <= '0;
                  end
               end
            end
            WORKING: begin
               if (w_gnt) begin
                  issued_q <= issued_q + TRANS_W'(1);
                  addr_q   <= addr_q + 32'(stride_q);
               end
               if (w_pop) begin
                  popped_q <= popped_q + TRANS_W'(1);
               end
               if (w_last) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
         unique case ({w_gnt, w_push})
            2'b10:   inflight_q <= inflight_q + CNT_W'(1);
            2'b01:   inflight_q <= inflight_q - CNT_W'(1);
            default: inflight_q <= inflight_q;
         endcase
      end
   end

   // Response FIFO occupancy and pointers; push and pop may coincide.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({w_push, w_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Response FIFO storage; data needs no reset since occupancy gates visibility.
   always_ff @(posedge clk_i) begin
      if (w_push) fifo_mem_q[wr_ptr_q] <= tcdm_r_data_i;
   end

`ifndef SYNTHESIS
   // Returned data must always belong to an outstanding request.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !clear_i && tcdm_r_valid_i && !drop_q) begin
         assert (inflight_q != '0)
            else $error("tcdm_r_valid_i received with no outstanding request");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hwpe_stream_tcdm_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hwpe_stream_tcdm_reader
//  Brief    : Self-checking bench for hwpe_stream_tcdm_reader. A TCDM model
//             returns address-derived data one cycle after each grant; the
//             expected address/data sequences are computed arithmetically.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hwpe_stream_tcdm_reader;

   localparam int FIFO_DEPTH = 4;
   localparam int TRANS_W    = 16;
   localparam int BUDGET     = 400;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               clear_i;
   logic               req_start_i;
   logic [31:0]        base_addr_i;
   logic [TRANS_W-1:0] trans_size_i;
   logic [TRANS_W-1:0] stride_i;
   logic               ready_start_o;
   logic               done_o;
   logic               tcdm_req_o;
   logic               tcdm_gnt_i;
   logic [31:0]        tcdm_add_o;
   logic               tcdm_wen_o;
   logic [3:0]         tcdm_be_o;
   logic [31:0]        tcdm_data_o;
   logic [31:0]        tcdm_r_data_i;
   logic               tcdm_r_valid_i;
   logic               stream_valid_o;
   logic               stream_ready_i;
   logic [31:0]        stream_data_o;
   logic [3:0]         stream_strb_o;

   int n_vec;
   int n_err;

   hwpe_stream_tcdm_reader #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TRANS_W    (TRANS_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .req_start_i    (req_start_i),
      .base_addr_i    (base_addr_i),
      .trans_size_i   (trans_size_i),
      .stride_i       (stride_i),
      .ready_start_o  (ready_start_o),
      .done_o         (done_o),
      .tcdm_req_o     (tcdm_req_o),
      .tcdm_gnt_i     (tcdm_gnt_i),
      .tcdm_add_o     (tcdm_add_o),
      .tcdm_wen_o     (tcdm_wen_o),
      .tcdm_be_o      (tcdm_be_o),
      .tcdm_data_o    (tcdm_data_o),
      .tcdm_r_data_i  (tcdm_r_data_i),
      .tcdm_r_valid_i (tcdm_r_valid_i),
      .stream_valid_o (stream_valid_o),
      .stream_ready_i (stream_ready_i),
      .stream_data_o  (stream_data_o),
      .stream_strb_o  (stream_strb_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit (vectors %0d)", n_vec);
      $fatal(1, "watchdog expired");
   end

   // Memory contents: a fixed function of the byte address and a per-transfer salt.
   function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic [31:0] s);
      return {a[15:0], a[31:16]} ^ s ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One complete transfer, entered and left at posedge+1.
   task automatic run_xfer(input logic [31:0] base, input int size, input logic [15:0] stride,
                           input int gnt_pct, input int rdy_pct, input int rdy_hold,
                           input int stall_word, input int clear_at);
      logic [31:0] salt, exp_a, rv_addr, rv_addr_next, wait_add;
      int  issued, popped, pushed, cyc, stall_left, post, done_cyc;
      bit  rv_pend, rv_next, wait_prev, finished, done_exp, aborted, clr_now, full_rate, pop;
      salt = $urandom;
      issued = 0; popped = 0; pushed = 0; stall_left = 3; post = 0; done_cyc = -1;
      rv_pend = 0; rv_next = 0; wait_prev = 0; aborted = 0;
      wait_add = '0; rv_addr = '0; rv_addr_next = '0;
      finished = (size == 0);
      done_exp = (size == 0);
      full_rate = (gnt_pct == 100) && (rdy_pct == 100) && (rdy_hold == 0) &&
                  (stall_word < 0) && (clear_at < 0) && (size > 0);

      clear_i        = 1'b0;
      tcdm_r_valid_i = 1'b0;
      req_start_i    = 1'b1;
      base_addr_i    = base;
      trans_size_i   = TRANS_W'(size);
      stride_i       = stride;
      @(negedge clk_i);
      chk("start_ready", 32'(ready_start_o), 32'd1);
      @(posedge clk_i); #1;
      base_addr_i  = $urandom;
      trans_size_i = TRANS_W'($urandom);
      stride_i     = TRANS_W'($urandom);

      cyc = 1;
      while (cyc <= BUDGET) begin
         clr_now        = (clear_at >= 0) && !aborted && (popped >= clear_at);
         clear_i        = clr_now;
         req_start_i    = (!finished && !aborted && !clr_now) ? 1'($urandom_range(0, 1)) : 1'b0;
         tcdm_r_valid_i = rv_pend;
         tcdm_r_data_i  = rv_pend ? mem_fn(rv_addr, salt) : $urandom;
         if (stall_word >= 0 && issued == stall_word && stall_left > 0)
            tcdm_gnt_i = 1'b0;
         else
            tcdm_gnt_i = ($urandom_range(1, 100) <= gnt_pct);
         if (clr_now || cyc <= rdy_hold)
            stream_ready_i = 1'b0;
         else
            stream_ready_i = ($urandom_range(1, 100) <= rdy_pct);

         @(negedge clk_i);
         rv_next = 0;
         if (aborted) begin
            chk("abort_req",   32'(tcdm_req_o),     32'd0);
            chk("abort_valid", 32'(stream_valid_o), 32'd0);
            chk("abort_done",  32'(done_o),         32'd0);
            chk("abort_ready", 32'(ready_start_o),  32'd1);
            chk("abort_add",   tcdm_add_o,          32'h0);
            post++;
         end else begin
            if (wait_prev) begin
               chk("req_hold", 32'(tcdm_req_o), 32'd1);
               chk("add_hold", tcdm_add_o, wait_add);
            end
            if (cyc == 1 && size > 0) chk("first_req", 32'(tcdm_req_o), 32'd1);
            if (tcdm_req_o) begin
               exp_a = base + 32'(issued) * {16'h0, stride};
               chk("req_in_budget", 32'(issued < size), 32'd1);
               chk("tcdm_add", tcdm_add_o, exp_a);
               if (tcdm_gnt_i) begin
                  issued++;
                  rv_next      = 1;
                  rv_addr_next = tcdm_add_o;
               end else if (stall_word >= 0 && issued == stall_word && stall_left > 0) begin
                  stall_left--;
               end
            end
            wait_prev = tcdm_req_o && !tcdm_gnt_i && !clr_now;
            wait_add  = tcdm_add_o;
            chk("in_flight_bound", 32'((issued - popped) <= FIFO_DEPTH), 32'd1);
            chk("stream_valid", 32'(stream_valid_o), 32'(pushed > popped));
            pop = stream_valid_o && stream_ready_i;
            if (stream_valid_o && popped < size)
               chk("stream_data", stream_data_o, mem_fn(base + 32'(popped) * {16'h0, stride}, salt));
            chk("done", 32'(done_o), 32'(done_exp));
            chk("ready_start", 32'(ready_start_o), 32'(finished));
            if (done_o) done_cyc = cyc;
            done_exp = 0;
            if (rv_pend) pushed++;
            if (pop) begin
               popped++;
               if (popped == size) begin
                  done_exp = 1;
                  finished = 1;
               end
            end
            if (finished) post++;
            if (clr_now) begin
               aborted = 1;
               post    = 0;
            end
         end
         rv_pend = rv_next;
         rv_addr = rv_addr_next;
         @(posedge clk_i); #1;
         cyc++;
         if ((finished || aborted) && post >= 3) break;
      end
      clear_i        = 1'b0;
      req_start_i    = 1'b0;
      tcdm_r_valid_i = 1'b0;
      chk("xfer_terminates", 32'((finished || aborted) && post >= 3), 32'd1);
      if (full_rate) chk("full_rate_latency", 32'(done_cyc), 32'(size + 3));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_ni         = 1'b0;
      clear_i        = 1'b0;
      req_start_i    = 1'b0;
      base_addr_i    = '0;
      trans_size_i   = '0;
      stride_i       = '0;
      tcdm_gnt_i     = 1'b0;
      tcdm_r_data_i  = '0;
      tcdm_r_valid_i = 1'b0;
      stream_ready_i = 1'b0;

      // Reset values
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_ready_start", 32'(ready_start_o),  32'd1);
      chk("rst_req",         32'(tcdm_req_o),     32'd0);
      chk("rst_add",         tcdm_add_o,          32'h0);
      chk("rst_valid",       32'(stream_valid_o), 32'd0);
      chk("rst_done",        32'(done_o),         32'd0);
      chk("const_wen",       32'(tcdm_wen_o),     32'd1);
      chk("const_be",        32'(tcdm_be_o),      32'hF);
      chk("const_wdata",     tcdm_data_o,         32'h0);
      chk("const_strb",      32'(stream_strb_o),  32'hF);
      rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Directed scenarios
      run_xfer(32'h0000_0100, 4, 16'h0004, 100, 100, 0,  -1, -1);
      run_xfer(32'h0000_0100, 3, 16'h0010, 100, 100, 0,   1, -1);
      run_xfer(32'h0000_0200, 8, 16'h0004, 100, 100, 20, -1, -1);
      run_xfer(32'h0000_0300, 0, 16'h0004, 100, 100, 0,  -1, -1);
      run_xfer(32'hFFFF_FFFC, 2, 16'h0004, 100, 100, 0,  -1, -1);
      run_xfer(32'h0000_0400, 6, 16'h0004, 100, 100, 0,  -1,  2);
      run_xfer(32'h0000_0500, 1, 16'h0004, 100, 100, 0,  -1, -1);

      // Randomized transfers with random grant/ready throttling
      for (int t = 0; t < 12; t++) begin
         run_xfer($urandom, int'($urandom_range(1, 12)), 16'($urandom_range(0, 64)),
                  int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                  int'($urandom_range(0, 6)),
                  ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, -1);
      end

      // Asynchronous reset in the middle of a transfer
      req_start_i    = 1'b1;
      base_addr_i    = 32'h0000_0600;
      trans_size_i   = TRANS_W'(8);
      stride_i       = TRANS_W'(4);
      tcdm_gnt_i     = 1'b1;
      stream_ready_i = 1'b0;
      tcdm_r_valid_i = 1'b0;
      @(posedge clk_i); #1;
      req_start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #3;
      chk("pre_reset_busy", 32'(ready_start_o), 32'd0);
      tcdm_gnt_i = 1'b0;
      rst_ni     = 1'b0;
      #1;
      chk("async_rst_req",   32'(tcdm_req_o),     32'd0);
      chk("async_rst_valid", 32'(stream_valid_o), 32'd0);
      chk("async_rst_ready", 32'(ready_start_o),  32'd1);
      chk("async_rst_add",   tcdm_add_o,          32'h0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      run_xfer(32'h0000_0700, 3, 16'h0008, 100, 100, 0, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
